// File: rtl/panel_sequencer_if.sv
// Memory bus between the front-panel sequencer and the memory controller.
//   mem_req   : request, held until mem_ack or timeout
//   mem_we    : 1 = write, valid with mem_req
//   mem_addr  : {field, address}, valid with mem_req
//   mem_wdata : write data, valid with mem_req
//   mem_ack   : one-cycle completion from memory
//   mem_rdata : read data, valid with mem_ack
// master = sequencer side, slave = memory side.
interface panel_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [11:0] mem_wdata;
  logic        mem_ack;
  logic [11:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/panel_sequencer.sv
// Front-panel command sequencer for a 12-bit minicomputer.
// Turns debounced switch pulses into register loads, memory deposit/examine
// cycles, and one-cycle clear/run requests to the CPU.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   halted          : panel memory/register commands allowed only when 1
//   cleard .. contd : one-cycle command pulses from the switches
//   sr              : switch register
//   mem             : memory bus (master side)
//   pc, ifld, dfld  : panel address register and fields
//   mb              : last deposited/examined word
//   clear_req       : one-cycle pulse to CPU clear logic
//   run_req         : one-cycle pulse to start the CPU
//   busy            : 1 whenever the sequencer is not idle
//   err             : sticky, set on rejected command or memory timeout
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting; latches any command pulses seen this cycle
// DECODE   | pick highest-priority command, do register loads, or reject
// MEM_REQ  | first cycle of a memory request (mem_req already high)
// MEM_WAIT | waiting for mem_ack; timeout down-counter running
// INCR     | advance pc after a completed deposit/examine
// PULSE    | drive clear_req or run_req for one cycle
module panel_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     halted,
  input  logic                     cleard,
  input  logic                     extd_addrd,
  input  logic                     addr_loadd,
  input  logic                     depd,
  input  logic                     examd,
  input  logic                     contd,
  input  logic [11:0]              sr,
  panel_sequencer_if.master        mem,
  output logic [11:0]              pc,
  output logic [2:0]               ifld,
  output logic [2:0]               dfld,
  output logic [11:0]              mb,
  output logic                     clear_req,
  output logic                     run_req,
  output logic                     busy,
  output logic                     err
);

  typedef enum logic [2:0] {
    IDLE, DECODE, MEM_REQ, MEM_WAIT, INCR, PULSE
  } state_t;

  // Bit positions in the latched command vector.
  localparam int CMD_CONT  = 0;
  localparam int CMD_EXAM  = 1;
  localparam int CMD_DEP   = 2;
  localparam int CMD_ADDR  = 3;
  localparam int CMD_EXTD  = 4;
  localparam int CMD_CLEAR = 5;

  localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [5:0]  cmd_q, cmd_d;
  logic [5:0]  cmd_sel;
  logic [11:0] pc_q, pc_d;
  logic [2:0]  ifld_q, ifld_d;
  logic [2:0]  dfld_q, dfld_d;
  logic [11:0] mb_q, mb_d;
  logic        err_q, err_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [14:0] mem_addr_q, mem_addr_d;
  logic [11:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]  tmr_q, tmr_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      pc_q        <= '0;
      ifld_q      <= '0;
      dfld_q      <= '0;
      mb_q        <= '0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tmr_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      pc_q        <= pc_d;
      ifld_q      <= ifld_d;
      dfld_q      <= dfld_d;
      mb_q        <= mb_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tmr_q       <= tmr_d;
    end
  end

  // Fixed priority: clear > extd_addr > addr_load > dep > exam > cont.
  always_comb begin
    cmd_sel = '0;
    if (cmd_q[CMD_CLEAR])     cmd_sel[CMD_CLEAR] = 1'b1;
    else if (cmd_q[CMD_EXTD]) cmd_sel[CMD_EXTD]  = 1'b1;
    else if (cmd_q[CMD_ADDR]) cmd_sel[CMD_ADDR]  = 1'b1;
    else if (cmd_q[CMD_DEP])  cmd_sel[CMD_DEP]   = 1'b1;
    else if (cmd_q[CMD_EXAM]) cmd_sel[CMD_EXAM]  = 1'b1;
    else if (cmd_q[CMD_CONT]) cmd_sel[CMD_CONT]  = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    pc_d        = pc_q;
    ifld_d      = ifld_q;
    dfld_d      = dfld_q;
    mb_d        = mb_q;
    err_d       = err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tmr_d       = tmr_q;

    case (state_q)
      IDLE: begin
        cmd_d = {cleard, extd_addrd, addr_loadd, depd, examd, contd};
        if (cmd_d != '0) state_d = DECODE;
      end

      DECODE: begin
        // Keep only the winning command so PULSE knows which strobe to drive.
        cmd_d   = cmd_sel;
        state_d = IDLE;
        if (cmd_sel[CMD_CLEAR]) begin
          err_d   = 1'b0;
          state_d = PULSE;
        end else if (!halted) begin
          err_d = 1'b1;
          cmd_d = '0;
        end else if (cmd_sel[CMD_EXTD]) begin
          ifld_d = sr[5:3];
          dfld_d = sr[2:0];
          cmd_d  = '0;
        end else if (cmd_sel[CMD_ADDR]) begin
          pc_d  = sr;
          cmd_d = '0;
        end else if (cmd_sel[CMD_DEP] || cmd_sel[CMD_EXAM]) begin
          mem_req_d   = 1'b1;
          mem_we_d    = cmd_sel[CMD_DEP];
          mem_addr_d  = {ifld_q, pc_q};
          mem_wdata_d = cmd_sel[CMD_DEP] ? sr : 12'd0;
          tmr_d       = TMR_LOAD;
          state_d     = MEM_REQ;
        end else if (cmd_sel[CMD_CONT]) begin
          state_d = PULSE;
        end else begin
          cmd_d = '0;
        end
      end

      MEM_REQ, MEM_WAIT: begin
        if (mem.mem_ack) begin
          mem_req_d = 1'b0;
          // A deposit records the word actually written, not a later sr value.
          mb_d      = mem_we_q ? mem_wdata_q : mem.mem_rdata;
          tmr_d     = '0;
          state_d   = INCR;
        end else if (tmr_q == 8'd1) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          tmr_d     = '0;
          cmd_d     = '0;
          state_d   = IDLE;
        end else begin
          tmr_d   = tmr_q - 8'd1;
          state_d = MEM_WAIT;
        end
      end

      INCR: begin
        pc_d    = pc_q + 12'd1;
        cmd_d   = '0;
        state_d = IDLE;
      end

      PULSE: begin
        cmd_d   = '0;
        state_d = IDLE;
      end

      default: begin
        cmd_d     = '0;
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

  assign pc        = pc_q;
  assign ifld      = ifld_q;
  assign dfld      = dfld_q;
  assign mb        = mb_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);
  assign clear_req = (state_q == PULSE) && cmd_q[CMD_CLEAR];
  assign run_req   = (state_q == PULSE) && cmd_q[CMD_CONT];

endmodule

// File: tb/tb_panel_sequencer.sv
// Self-checking bench for panel_sequencer. Expected memory transactions are
// queued when a command is issued and compared when the DUT raises mem_req.
module tb_panel_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        halted = 1'b1;
  logic        cleard = 1'b0, extd_addrd = 1'b0, addr_loadd = 1'b0;
  logic        depd = 1'b0, examd = 1'b0, contd = 1'b0;
  logic [11:0] sr = '0;
  logic [11:0] pc, mb;
  logic [2:0]  ifld, dfld;
  logic        clear_req, run_req, busy, err;

  panel_sequencer_if mem_if ();

  panel_sequencer #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .halted     (halted),
    .cleard     (cleard),
    .extd_addrd (extd_addrd),
    .addr_loadd (addr_loadd),
    .depd       (depd),
    .examd      (examd),
    .contd      (contd),
    .sr         (sr),
    .mem        (mem_if),
    .pc         (pc),
    .ifld       (ifld),
    .dfld       (dfld),
    .mb         (mb),
    .clear_req  (clear_req),
    .run_req    (run_req),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [14:0] addr;
    logic [11:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Bench model of the panel registers.
  logic [11:0] exp_pc = '0;
  logic [2:0]  exp_ifld = '0;
  logic [11:0] exp_mb = '0;

  localparam logic [5:0] C_CLEAR = 6'b100000;
  localparam logic [5:0] C_EXTD  = 6'b010000;
  localparam logic [5:0] C_ADDR  = 6'b001000;
  localparam logic [5:0] C_DEP   = 6'b000100;
  localparam logic [5:0] C_EXAM  = 6'b000010;
  localparam logic [5:0] C_CONT  = 6'b000001;

  task automatic pulse(input logic [5:0] c);
    @(negedge clk);
    {cleard, extd_addrd, addr_loadd, depd, examd, contd} = c;
    @(negedge clk);
    {cleard, extd_addrd, addr_loadd, depd, examd, contd} = '0;
  endtask

  // Memory responder: waits (bounded) for mem_req, records the request,
  // watches it stay stable for `delay` cycles, then returns a one-cycle ack.
  task automatic serve_mem(input int delay, input logic [11:0] rdata,
                           output bit seen, output txn_t obs, output bit stable);
    seen = 1'b0;
    stable = 1'b1;
    obs.we = 1'b0; obs.addr = '0; obs.wdata = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_if.mem_req === 1'b1) seen = 1'b1;
    end
    if (!seen) return;
    obs.we = mem_if.mem_we;
    obs.addr = mem_if.mem_addr;
    obs.wdata = mem_if.mem_wdata;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (mem_if.mem_req !== 1'b1 || mem_if.mem_we !== obs.we ||
          mem_if.mem_addr !== obs.addr || mem_if.mem_wdata !== obs.wdata)
        stable = 1'b0;
    end
    mem_if.mem_ack = 1'b1;
    mem_if.mem_rdata = rdata;
    @(negedge clk);
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = '0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, pc, ifld,
         dfld, mb, clear_req, run_req, busy, err} !== 63'd0) begin
      failures++;
      $display("FAIL reset_state got pc=%o mb=%o req=%b busy=%b err=%b exp all zero",
               pc, mb, mem_if.mem_req, busy, err);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_deposit;
    bit seen, stable;
    txn_t obs, e;
    halted = 1'b1;
    sr = 12'o0200;
    pulse(C_ADDR);
    @(negedge clk);
    exp_pc = 12'o0200;
    checks++;
    if (pc !== exp_pc) begin
      failures++; $display("FAIL addr_load_pc got=%o exp=%o", pc, exp_pc);
    end
    sr = 12'o7402;
    exp_q.push_back('{we: 1'b1, addr: {exp_ifld, exp_pc}, wdata: 12'o7402});
    pulse(C_DEP);
    serve_mem(3, 12'o0000, seen, obs, stable);
    e = exp_q.pop_front();
    checks++;
    if (!seen || obs.we !== e.we || obs.addr !== e.addr || obs.wdata !== e.wdata) begin
      failures++;
      $display("FAIL dep_txn got seen=%b we=%b addr=%o wdata=%o exp we=%b addr=%o wdata=%o",
               seen, obs.we, obs.addr, obs.wdata, e.we, e.addr, e.wdata);
    end
    checks++;
    if (!stable) begin failures++; $display("FAIL dep_stable got=0 exp=1"); end
    checks++;
    if (mem_if.mem_req !== 1'b0) begin
      failures++; $display("FAIL dep_req_drop got=%b exp=0", mem_if.mem_req);
    end
    @(negedge clk);
    exp_pc = exp_pc + 12'd1;
    exp_mb = 12'o7402;
    checks++;
    if (pc !== exp_pc || mb !== exp_mb || busy !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL dep_result got pc=%o mb=%o busy=%b err=%b exp pc=%o mb=%o busy=0 err=0",
               pc, mb, busy, err, exp_pc, exp_mb);
    end
  endtask

  task automatic test_exam_wrap;
    bit seen, stable;
    txn_t obs, e;
    sr = 12'o0050;
    pulse(C_EXTD);
    @(negedge clk);
    exp_ifld = 3'd5;
    checks++;
    if (ifld !== exp_ifld || dfld !== 3'd0) begin
      failures++; $display("FAIL extd_fields got ifld=%0d dfld=%0d exp 5 0", ifld, dfld);
    end
    sr = 12'o7777;
    pulse(C_ADDR);
    @(negedge clk);
    exp_pc = 12'o7777;
    sr = 12'o0000;
    exp_q.push_back('{we: 1'b0, addr: {exp_ifld, exp_pc}, wdata: 12'o0000});
    pulse(C_EXAM);
    serve_mem(1, 12'o1234, seen, obs, stable);
    e = exp_q.pop_front();
    checks++;
    if (!seen || obs.we !== e.we || obs.addr !== e.addr) begin
      failures++;
      $display("FAIL exam_txn got seen=%b we=%b addr=%o exp we=%b addr=%o",
               seen, obs.we, obs.addr, e.we, e.addr);
    end
    @(negedge clk);
    exp_pc = exp_pc + 12'd1;
    exp_mb = 12'o1234;
    checks++;
    if (pc !== exp_pc || mb !== exp_mb || ifld !== exp_ifld) begin
      failures++;
      $display("FAIL exam_wrap got pc=%o mb=%o ifld=%0d exp pc=%o mb=%o ifld=%0d",
               pc, mb, ifld, exp_pc, exp_mb, exp_ifld);
    end
  endtask

  task automatic test_dep_exam_same;
    bit seen, stable;
    txn_t obs, e;
    int extra;
    sr = 12'o4321;
    exp_q.push_back('{we: 1'b1, addr: {exp_ifld, exp_pc}, wdata: 12'o4321});
    pulse(C_DEP | C_EXAM);
    serve_mem(2, 12'o7070, seen, obs, stable);
    e = exp_q.pop_front();
    checks++;
    if (!seen || obs.we !== e.we || obs.addr !== e.addr || obs.wdata !== e.wdata) begin
      failures++;
      $display("FAIL dep_exam_txn got seen=%b we=%b addr=%o wdata=%o exp we=%b addr=%o wdata=%o",
               seen, obs.we, obs.addr, obs.wdata, e.we, e.addr, e.wdata);
    end
    @(negedge clk);
    exp_pc = exp_pc + 12'd1;
    exp_mb = 12'o4321;
    checks++;
    if (pc !== exp_pc || mb !== exp_mb) begin
      failures++;
      $display("FAIL dep_exam_result got pc=%o mb=%o exp pc=%o mb=%o", pc, mb, exp_pc, exp_mb);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_if.mem_req === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++; $display("FAIL dep_exam_single got extra_req_cycles=%0d exp=0", extra);
    end
  endtask

  task automatic test_not_halted;
    int reqs, clears;
    halted = 1'b0;
    sr = 12'o5555;
    pulse(C_DEP);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_if.mem_req === 1'b1) reqs++;
    end
    checks++;
    if (reqs !== 0 || err !== 1'b1 || pc !== exp_pc || mb !== exp_mb) begin
      failures++;
      $display("FAIL reject got reqs=%0d err=%b pc=%o mb=%o exp reqs=0 err=1 pc=%o mb=%o",
               reqs, err, pc, mb, exp_pc, exp_mb);
    end
    pulse(C_CLEAR);
    clears = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (clear_req === 1'b1) clears++;
    end
    checks++;
    if (clears !== 1 || err !== 1'b0 || pc !== exp_pc || mb !== exp_mb) begin
      failures++;
      $display("FAIL clear got pulses=%0d err=%b pc=%o mb=%o exp pulses=1 err=0 pc=%o mb=%o",
               clears, err, pc, mb, exp_pc, exp_mb);
    end
    halted = 1'b1;
  endtask

  task automatic test_cont;
    int runs;
    pulse(C_CONT);
    runs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (run_req === 1'b1) runs++;
    end
    checks++;
    if (runs !== 1 || pc !== exp_pc || busy !== 1'b0) begin
      failures++;
      $display("FAIL cont got pulses=%0d pc=%o busy=%b exp pulses=1 pc=%o busy=0",
               runs, pc, busy, exp_pc);
    end
  endtask

  task automatic test_timeout;
    int hi;
    bit seen;
    txn_t e;
    exp_q.push_back('{we: 1'b0, addr: {exp_ifld, exp_pc}, wdata: 12'o0000});
    pulse(C_EXAM);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_if.mem_req === 1'b1) seen = 1'b1;
    end
    e = exp_q.pop_front();
    checks++;
    if (!seen || mem_if.mem_we !== e.we || mem_if.mem_addr !== e.addr) begin
      failures++;
      $display("FAIL timeout_txn got seen=%b we=%b addr=%o exp we=%b addr=%o",
               seen, mem_if.mem_we, mem_if.mem_addr, e.we, e.addr);
    end
    hi = seen ? 1 : 0;
    for (int i = 0; i < 40 && seen; i++) begin
      @(negedge clk);
      if (mem_if.mem_req === 1'b1) hi++;
      else break;
    end
    checks++;
    if (hi !== 16) begin
      failures++; $display("FAIL timeout_len got=%0d exp=16", hi);
    end
    checks++;
    if (err !== 1'b1 || pc !== exp_pc || mb !== exp_mb || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_state got err=%b pc=%o mb=%o busy=%b exp err=1 pc=%o mb=%o busy=0",
               err, pc, mb, busy, exp_pc, exp_mb);
    end
    pulse(C_CLEAR);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit seen, stable;
    txn_t obs, e;
    seen = 1'b0;
    exp_q.push_back('{we: 1'b0, addr: {exp_ifld, exp_pc}, wdata: 12'o0000});
    pulse(C_EXAM);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_if.mem_req === 1'b1) seen = 1'b1;
    end
    e = exp_q.pop_front();
    checks++;
    if (!seen || mem_if.mem_addr !== e.addr) begin
      failures++;
      $display("FAIL reset_mid_txn got seen=%b addr=%o exp addr=%o", seen, mem_if.mem_addr, e.addr);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, pc, ifld,
         dfld, mb, clear_req, run_req, busy, err} !== 63'd0) begin
      failures++;
      $display("FAIL reset_mid got req=%b pc=%o ifld=%0d mb=%o busy=%b exp all zero",
               mem_if.mem_req, pc, ifld, mb, busy);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_pc = '0; exp_ifld = '0; exp_mb = '0;
    sr = 12'o1111;
    pulse(C_ADDR);
    @(negedge clk);
    exp_pc = 12'o1111;
    sr = 12'o2222;
    exp_q.push_back('{we: 1'b1, addr: {exp_ifld, exp_pc}, wdata: 12'o2222});
    pulse(C_DEP);
    serve_mem(1, 12'o0000, seen, obs, stable);
    e = exp_q.pop_front();
    @(negedge clk);
    exp_pc = exp_pc + 12'd1;
    exp_mb = 12'o2222;
    checks++;
    if (!seen || obs.addr !== e.addr || obs.wdata !== e.wdata || pc !== exp_pc || mb !== exp_mb) begin
      failures++;
      $display("FAIL after_reset got addr=%o wdata=%o pc=%o mb=%o exp addr=%o wdata=%o pc=%o mb=%o",
               obs.addr, obs.wdata, pc, mb, e.addr, e.wdata, exp_pc, exp_mb);
    end
  endtask

  initial begin
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = '0;
    test_reset();
    test_deposit();
    test_exam_wrap();
    test_dep_exam_same();
    test_not_halted();
    test_cont();
    test_timeout();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/panel_sequencer.md
PANEL_SEQUENCER -- requirements
Module: panel_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning max clk cycles allowed waiting for mem_ack (legal 2..255).
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
  clk  in  1  system clock; all state changes on rising edge
  reset  in  1  asynchronous, active-low reset
  halted  in  1  CPU halted; panel memory/register commands permitted only when 1
  cleard  in  1  debounced one-cycle pulse: CLEAR switch
  extd_addrd  in  1  one-cycle pulse: EXTD ADDR LOAD switch
  addr_loadd  in  1  one-cycle pulse: ADDR LOAD switch
  depd  in  1  one-cycle pulse: DEP switch
  examd  in  1  one-cycle pulse: EXAM switch
  contd  in  1  one-cycle pulse: CONT switch
  sr  in  12  switch register
  mem_req  out  1  memory request, held until mem_ack or timeout
  mem_we  out  1  1 = write, valid with mem_req
  mem_addr  out  15  {field, address}, valid with mem_req
  mem_wdata  out  12  write data, valid with mem_req
  mem_ack  in  1  one-cycle memory completion
  mem_rdata  in  12  read data, valid with mem_ack
  pc  out  12  panel address register
  ifld  out  3  instruction field
  dfld  out  3  data field
  mb  out  12  last deposited/examined word
  clear_req  out  1  one-cycle pulse to CPU clear logic
  run_req  out  1  one-cycle pulse to start CPU
  busy  out  1  1 whenever state != IDLE
  err  out  1  sticky: command rejected or memory timeout

Function
REQ-003 SHALL implement states IDLE, DECODE, MEM_REQ, MEM_WAIT, INCR, PULSE.
REQ-004 SHALL, in IDLE, capture any asserted command pulses into a latched command vector and move to DECODE next cycle; pulses arriving while busy=1 SHALL be discarded.
REQ-005 SHALL, in DECODE, select one command by priority clear > extd_addr > addr_load > dep > exam > cont; lower-priority simultaneous commands SHALL be dropped.
REQ-006 SHALL, if halted=0 in DECODE and command is not clear, set err=1 and return to IDLE with no other effect.
REQ-007 SHALL, for clear: pulse clear_req for exactly one cycle (PULSE state), return to IDLE; pc, fields, mb unchanged.
REQ-008 SHALL, for extd_addr: ifld<=sr[5:3], dfld<=sr[2:0] in DECODE, return to IDLE.
REQ-009 SHALL, for addr_load: pc<=sr in DECODE, return to IDLE.
REQ-010 SHALL, for dep: enter MEM_REQ with mem_we=1, mem_addr={ifld,pc}, mem_wdata=sr; on mem_ack mb<=sr, go INCR.
REQ-011 SHALL, for exam: enter MEM_REQ with mem_we=0, mem_addr={ifld,pc}; on mem_ack mb<=mem_rdata, go INCR.
REQ-012 SHALL assert mem_req from entry to MEM_REQ through the cycle mem_ack=1; MEM_REQ lasts one cycle then MEM_WAIT; mem_ack sampled in MEM_REQ or MEM_WAIT.
REQ-013 SHALL hold mem_addr, mem_we, mem_wdata stable while mem_req=1.
REQ-014 SHALL, in INCR, set pc<=pc+1 modulo 4096 (7777 octal wraps to 0000; ifld unchanged), then IDLE.
REQ-015 SHALL count cycles with mem_req=1; if TIMEOUT cycles elapse without mem_ack, drop mem_req, set err=1, leave pc and mb unchanged, return to IDLE.
REQ-016 SHALL, for cont: pulse run_req for exactly one cycle, return to IDLE.
REQ-017 SHALL clear err only on an accepted clear command (cleared in the DECODE cycle, not on reject).
REQ-018 SHALL ignore mem_ack when mem_req=0.

Reset
REQ-019 SHALL, on reset=0, asynchronously force state IDLE, pc=0, ifld=0, dfld=0, mb=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, clear_req=0, run_req=0, busy=0, err=0, timeout counter=0, latched commands=0.
REQ-020 SHALL abandon any in-flight memory request on reset with mem_req dropping immediately.

Verification
REQ-021 halted=1, sr=0o0200, addr_loadd; sr=0o7402, depd (ack after 3 cycles) -> mem_addr=0o00200, mem_wdata=0o7402, mb=0o7402, pc=0o0201.
REQ-022 pc=0o7777, ifld=5, examd, mem_rdata=0o1234 -> mem_addr=0o57777, mb=0o1234, pc=0o0000, ifld=5.
REQ-023 depd and examd same cycle -> only one write; mem_we=1; exam dropped.
REQ-024 halted=0, depd -> no mem_req, err=1; then cleard -> clear_req one cycle, err=0.
REQ-025 examd, mem_ack never asserted, TIMEOUT=16 -> mem_req drops after 16 cycles, err=1, pc unchanged.
REQ-026 reset=0 during MEM_WAIT -> mem_req=0 same cycle, all outputs at reset values; commands accepted after reset release.
